// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-number arbiter slice.
// Holds the arbiter FSM state encoding and the LFSR default seed.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_SERVE  = 2'd0,
        ST_SEED   = 2'd1,
        ST_WARMUP = 2'd2
    } state_t;

    localparam int DEFAULT_SEED = 1;

endpackage

// File: rtl/lfsr_core.sv
// Shift-right LFSR register; load has priority over step, holds otherwise.
// Ports: clk, areset (async, active-low), step, load, load_value, q.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int No_of_Bits = 5
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  step,
    input  logic                  load,
    input  logic [No_of_Bits-1:0] load_value,
    output logic [No_of_Bits-1:0] q
);

    logic [No_of_Bits-1:0] r_q;
    logic [No_of_Bits-1:0] w_next;

    assign w_next = {^r_q[No_of_Bits-2:0], r_q[No_of_Bits-1:1]};

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_q <= No_of_Bits'(DEFAULT_SEED);
        end else if (load) begin
            r_q <= load_value;
        end else if (step) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin sharing of one LFSR among N_REQ requesters, with seeding and warm-up.
// Ports: clk, areset, seed_load, seed_value, req -> gnt, rnd_out, busy.
module lfsr_rng_arbiter
    import lfsr_pkg::*;
#(
    parameter int No_of_Bits    = 5,
    parameter int N_REQ         = 4,
    parameter int WARMUP_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  seed_load,
    input  logic [No_of_Bits-1:0] seed_value,
    input  logic [N_REQ-1:0]      req,
    output logic [N_REQ-1:0]      gnt,
    output logic [No_of_Bits-1:0] rnd_out,
    output logic                  busy
);

    localparam int PW  = $clog2(N_REQ);
    localparam int WCW = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES + 1);

    // Rotate so rr_ptr sits at bit 0, keep the lowest set bit, rotate back.
    function automatic logic [N_REQ-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [PW-1:0]    p
    );
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [N_REQ-1:0]   pk;
        dbl = {r, r} >> p;
        rot = dbl[N_REQ-1:0];
        pk  = rot & (~rot + N_REQ'(1));
        dbl = {pk, pk} << p;
        return dbl[2*N_REQ-1:N_REQ];
    endfunction

    function automatic logic [PW-1:0] oh2idx(input logic [N_REQ-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (oh[k]) idx = PW'(k);
        end
        return idx;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_REQ-1:0]      r_gnt;
    logic [N_REQ-1:0]      w_gnt_nxt;
    logic [No_of_Bits-1:0] r_rnd;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         w_ptr_nxt;
    logic [WCW-1:0]        r_cnt;
    logic [WCW-1:0]        w_cnt_nxt;
    logic [No_of_Bits-1:0] r_seed;
    logic [No_of_Bits-1:0] w_seed_eff;
    logic [No_of_Bits-1:0] w_q;
    logic [N_REQ-1:0]      w_pick;
    logic [PW-1:0]         w_gidx;
    logic                  w_step;
    logic                  w_load;

    lfsr_core #(
        .No_of_Bits(No_of_Bits)
    ) u_core (
        .clk       (clk),
        .areset    (areset),
        .step      (w_step),
        .load      (w_load),
        .load_value(w_seed_eff),
        .q         (w_q)
    );

    // All-zero seed would lock the LFSR; substitute the default.
    assign w_seed_eff = (r_seed == '0) ? No_of_Bits'(DEFAULT_SEED) : r_seed;

    assign w_pick    = rr_pick(req, r_ptr);
    assign w_gidx    = oh2idx(w_pick);
    assign w_ptr_nxt = (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + PW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = r_cnt;
        w_step      = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            ST_SERVE: begin
                if (seed_load) begin
                    w_state_nxt = ST_SEED;
                end else if (|req) begin
                    w_gnt_nxt = w_pick;
                    w_step    = 1'b1;
                end
            end
            ST_SEED: begin
                // A repeated pulse keeps us here; the newest seed is used.
                if (!seed_load) begin
                    w_load    = 1'b1;
                    w_cnt_nxt = WCW'(WARMUP_CYCLES);
                    w_state_nxt = (WARMUP_CYCLES > 0) ? ST_WARMUP : ST_SERVE;
                end
            end
            ST_WARMUP: begin
                if (seed_load) begin
                    w_state_nxt = ST_SEED;
                end else begin
                    w_step    = 1'b1;
                    w_cnt_nxt = r_cnt - WCW'(1);
                    if (r_cnt == WCW'(1)) w_state_nxt = ST_SERVE;
                end
            end
            default: w_state_nxt = ST_SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state <= ST_SERVE;
            r_gnt   <= '0;
            r_rnd   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_seed  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            if (seed_load) r_seed <= seed_value;
            if (|w_gnt_nxt) begin
                r_rnd <= w_q;
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign gnt     = r_gnt;
    assign rnd_out = r_rnd;
    assign busy    = (r_state != ST_SERVE);

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench for lfsr_rng_arbiter: vector table plus warm-up and reset sequences.
// Two instances: warm-up 0 (main) and warm-up 4, sharing the same stimulus.
module tb_lfsr_rng_arbiter;

    logic       clk;
    logic       areset;
    logic       seed_load;
    logic [4:0] seed_value;
    logic [3:0] req;
    logic [3:0] gnt0, gnt4;
    logic [4:0] rnd0, rnd4;
    logic       busy0, busy4;

    int total = 0;
    int bad   = 0;

    lfsr_rng_arbiter #(.No_of_Bits(5), .N_REQ(4), .WARMUP_CYCLES(0)) dut (
        .clk(clk), .areset(areset), .seed_load(seed_load),
        .seed_value(seed_value), .req(req),
        .gnt(gnt0), .rnd_out(rnd0), .busy(busy0)
    );

    lfsr_rng_arbiter #(.No_of_Bits(5), .N_REQ(4), .WARMUP_CYCLES(4)) dut_w (
        .clk(clk), .areset(areset), .seed_load(seed_load),
        .seed_value(seed_value), .req(req),
        .gnt(gnt4), .rnd_out(rnd4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Per-cycle invariants on both instances.
    always @(negedge clk) begin
        if (areset) begin
            total++;
            if (!$onehot0(gnt0) || (busy0 && gnt0 != '0) || dut.w_q == '0) begin
                bad++;
                $display("FAIL inv0 gnt=%b busy=%b q=%b", gnt0, busy0, dut.w_q);
            end
            total++;
            if (!$onehot0(gnt4) || (busy4 && gnt4 != '0) || dut_w.w_q == '0) begin
                bad++;
                $display("FAIL inv4 gnt=%b busy=%b q=%b", gnt4, busy4, dut_w.w_q);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        areset     = 1'b0;
        req        = '0;
        seed_load  = 1'b0;
        seed_value = '0;
        tick();
        chk("rst_gnt", 32'(gnt0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_rnd", 32'(rnd0), 32'h0);
        chk("rst_busy_w", 32'(busy4), 32'h0);
        areset = 1'b1;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       sl;
        logic [4:0] sv;
        logic [3:0] gnt;
        logic [4:0] rnd;
        logic       crnd;
        logic       busy;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic rst, input logic [3:0] rq, input logic sl, input logic [4:0] sv,
        input logic [3:0] g, input logic [4:0] rn, input logic cr, input logic b
    );
        vec_t v;
        v.rst = rst; v.req = rq; v.sl = sl; v.sv = sv;
        v.gnt = g; v.rnd = rn; v.crnd = cr; v.busy = b;
        return v;
    endfunction

    // Wait for the warm-up instance to leave busy and grant requester 1.
    task automatic warm_wait(input string tag);
        int   nbusy;
        logic got;
        nbusy = 0;
        got   = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (gnt4 != '0) begin
                got = 1'b1;
                chk({tag, "_gnt"}, 32'(gnt4), 32'h2);
                chk({tag, "_rnd"}, 32'(rnd4), 32'h1A);
            end else begin
                if (busy4) nbusy++;
                tick();
            end
        end
        chk({tag, "_granted"}, 32'(got), 32'h1);
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd5);
    endtask

    initial begin
        areset     = 1'b1;
        req        = '0;
        seed_load  = 1'b0;
        seed_value = '0;

        // single requester, three grants
        tv.push_back(mk(1, 4'b0001, 0, 5'h00, 4'b0001, 5'b00001, 1, 0));
        tv.push_back(mk(0, 4'b0001, 0, 5'h00, 4'b0001, 5'b10000, 1, 0));
        tv.push_back(mk(0, 4'b0001, 0, 5'h00, 4'b0001, 5'b01000, 1, 0));
        tv.push_back(mk(0, 4'b0000, 0, 5'h00, 4'b0000, 5'b00000, 0, 0));
        // all requesting: 0,1,2,3,0,1,2,3
        tv.push_back(mk(1, 4'b1111, 0, 5'h00, 4'b0001, 5'b00001, 1, 0));
        tv.push_back(mk(0, 4'b1111, 0, 5'h00, 4'b0010, 5'b10000, 1, 0));
        tv.push_back(mk(0, 4'b1111, 0, 5'h00, 4'b0100, 5'b01000, 1, 0));
        tv.push_back(mk(0, 4'b1111, 0, 5'h00, 4'b1000, 5'b10100, 1, 0));
        tv.push_back(mk(0, 4'b1111, 0, 5'h00, 4'b0001, 5'b11010, 1, 0));
        tv.push_back(mk(0, 4'b1111, 0, 5'h00, 4'b0010, 5'b01101, 1, 0));
        tv.push_back(mk(0, 4'b1111, 0, 5'h00, 4'b0100, 5'b10110, 1, 0));
        tv.push_back(mk(0, 4'b1111, 0, 5'h00, 4'b1000, 5'b01011, 1, 0));
        tv.push_back(mk(0, 4'b0000, 0, 5'h00, 4'b0000, 5'b01011, 1, 0));
        // zero seed becomes 00001, busy one cycle
        tv.push_back(mk(0, 4'b0000, 1, 5'h00, 4'b0000, 5'b00000, 0, 1));
        tv.push_back(mk(0, 4'b0100, 0, 5'h00, 4'b0000, 5'b00000, 0, 0));
        tv.push_back(mk(0, 4'b0100, 0, 5'h00, 4'b0100, 5'b00001, 1, 0));
        tv.push_back(mk(0, 4'b0000, 0, 5'h00, 4'b0000, 5'b00000, 0, 0));
        // seed_load beats a pending request
        tv.push_back(mk(0, 4'b1000, 1, 5'h16, 4'b0000, 5'b00000, 0, 1));
        tv.push_back(mk(0, 4'b1000, 0, 5'h16, 4'b0000, 5'b00000, 0, 0));
        tv.push_back(mk(0, 4'b1000, 0, 5'h16, 4'b1000, 5'b10110, 1, 0));
        tv.push_back(mk(0, 4'b0000, 0, 5'h16, 4'b0000, 5'b00000, 0, 0));
        // sparse requests, pointer hold and wrap
        tv.push_back(mk(0, 4'b1010, 0, 5'h00, 4'b0010, 5'b01011, 1, 0));
        tv.push_back(mk(0, 4'b1010, 0, 5'h00, 4'b1000, 5'b10101, 1, 0));
        tv.push_back(mk(0, 4'b1010, 0, 5'h00, 4'b0010, 5'b01010, 1, 0));
        tv.push_back(mk(0, 4'b0000, 0, 5'h00, 4'b0000, 5'b01010, 1, 0));
        tv.push_back(mk(0, 4'b0101, 0, 5'h00, 4'b0100, 5'b00101, 1, 0));
        tv.push_back(mk(0, 4'b0101, 0, 5'h00, 4'b0001, 5'b00010, 1, 0));
        // second pulse while in SEED restarts it with the newer seed
        tv.push_back(mk(0, 4'b0000, 1, 5'h07, 4'b0000, 5'b00000, 0, 1));
        tv.push_back(mk(0, 4'b0001, 1, 5'h09, 4'b0000, 5'b00000, 0, 1));
        tv.push_back(mk(0, 4'b0001, 0, 5'h09, 4'b0000, 5'b00000, 0, 0));
        tv.push_back(mk(0, 4'b0001, 0, 5'h09, 4'b0001, 5'b01001, 1, 0));

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst) reset_all();
            req        = tv[i].req;
            seed_load  = tv[i].sl;
            seed_value = tv[i].sv;
            tick();
            chk($sformatf("vec%0d_gnt", i), 32'(gnt0), 32'(tv[i].gnt));
            chk($sformatf("vec%0d_busy", i), 32'(busy0), 32'(tv[i].busy));
            if (tv[i].crnd)
                chk($sformatf("vec%0d_rnd", i), 32'(rnd0), 32'(tv[i].rnd));
        end
        seed_load = 1'b0;

        // warm-up of 4 with request raised alongside the seed pulse
        reset_all();
        seed_value = 5'b00001;
        seed_load  = 1'b1;
        req        = 4'b0010;
        tick();
        seed_load = 1'b0;
        warm_wait("warm");

        // seed pulse during warm-up restarts seeding and the count
        reset_all();
        seed_value = 5'b01111;
        seed_load  = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        tick();
        chk("restart_pre_busy", 32'(busy4), 32'h1);
        seed_value = 5'b00001;
        seed_load  = 1'b1;
        req        = 4'b0010;
        tick();
        seed_load = 1'b0;
        warm_wait("restart");

        // asynchronous reset clears busy mid warm-up
        reset_all();
        seed_value = 5'b00011;
        seed_load  = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("abusy_pre", 32'(busy4), 32'h1);
        #2 areset = 1'b0;
        #1 chk("abusy_post", 32'(busy4), 32'h0);
        @(negedge clk);
        #1 areset = 1'b1;

        // asynchronous reset mid-stream of grants
        reset_all();
        req = 4'b1111;
        tick();
        tick();
        chk("arst_pre_gnt", 32'(gnt0), 32'h2);
        #2 areset = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt0), 32'h0);
        chk("arst_busy", 32'(busy0), 32'h0);
        chk("arst_rnd", 32'(rnd0), 32'h0);
        @(negedge clk);
        #1 areset = 1'b1;
        tick();
        chk("arst_first_gnt", 32'(gnt0), 32'h1);
        chk("arst_first_rnd", 32'(rnd0), 32'h01);
        req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
